// File: rtl/bo_pkg.sv
// bo_pkg: shared constants for the bo_datapath polynomial datapath.
//   BO_WIDTH       default data width
//   SEL0_*         coefficient mux (M0) encodings
//   SEL1_*         ALU operand-1 mux (M1) encodings
//   SEL2_*         ALU operand-2 mux (M2) encodings
//   OP_ADD/OP_MUL  ALU operation select (H)
package bo_pkg;

  localparam int BO_WIDTH = 16;

  // Coefficient mux M0
  localparam logic [1:0] SEL0_ZERO = 2'd0;
  localparam logic [1:0] SEL0_A    = 2'd1;
  localparam logic [1:0] SEL0_B    = 2'd2;
  localparam logic [1:0] SEL0_C    = 2'd3;

  // Operand-1 mux M1
  localparam logic [1:0] SEL1_M0 = 2'd0;
  localparam logic [1:0] SEL1_R0 = 2'd1;
  localparam logic [1:0] SEL1_R1 = 2'd2;
  localparam logic [1:0] SEL1_R2 = 2'd3;

  // Operand-2 mux M2 (note R0 and M0 swap places relative to M1)
  localparam logic [1:0] SEL2_R0 = 2'd0;
  localparam logic [1:0] SEL2_M0 = 2'd1;
  localparam logic [1:0] SEL2_R1 = 2'd2;
  localparam logic [1:0] SEL2_R2 = 2'd3;

  // ALU operation
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/bo_reg.sv
// bo_reg: WIDTH-bit register with synchronous active-high reset and load enable.
//   clk   rising-edge clock
//   rst   synchronous reset, clears the register; wins over ld
//   ld    load enable; register holds when low
//   d     data in
//   q     registered data out
module bo_reg
  import bo_pkg::*;
#(
  parameter int WIDTH = BO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)     r_q <= '0;
    else if (ld) r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/bo_datapath.sv
// bo_datapath: 16-bit operational block for evaluating polynomials such as
// A*x^2 + B*x + C, sequenced cycle by cycle by an external control FSM.
//   clk, rst      clock and synchronous active-high reset (clears R0..R2)
//   A, B, C       coefficients, selected by M0 (0, A, B, C)
//   x, LX         polynomial variable and load enable for R0
//   M1            ALU operand 1: M0-out, R0, R1, R2
//   M2            ALU operand 2: R0, M0-out, R1, R2
//   H             ALU op: 1 multiply, 0 add (unsigned, mod 2^WIDTH)
//   LH, LS        load enables for R1 and R2 from the ALU result
//   Pronto        result, always equal to R2
module bo_datapath
  import bo_pkg::*;
#(
  parameter int WIDTH = BO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [1:0]       M0,
  input  logic [WIDTH-1:0] x,
  input  logic             LX,
  input  logic [1:0]       M1,
  input  logic [1:0]       M2,
  input  logic             LH,
  input  logic             LS,
  input  logic             H,
  output logic [WIDTH-1:0] Pronto
);

  logic [WIDTH-1:0] w_r0, w_r1, w_r2;
  logic [WIDTH-1:0] w_mux0, w_op1, w_op2;
  logic [WIDTH-1:0] w_sum, w_prod, w_alu;

  // Coefficient mux; the zero leg is a real constant so nothing X leaks in.
  always_comb begin
    w_mux0 = '0;
    unique case (M0)
      SEL0_ZERO: w_mux0 = '0;
      SEL0_A:    w_mux0 = A;
      SEL0_B:    w_mux0 = B;
      SEL0_C:    w_mux0 = C;
      default:   w_mux0 = '0;
    endcase
  end

  always_comb begin
    w_op1 = '0;
    unique case (M1)
      SEL1_M0: w_op1 = w_mux0;
      SEL1_R0: w_op1 = w_r0;
      SEL1_R1: w_op1 = w_r1;
      SEL1_R2: w_op1 = w_r2;
      default: w_op1 = '0;
    endcase
  end

  always_comb begin
    w_op2 = '0;
    unique case (M2)
      SEL2_R0: w_op2 = w_r0;
      SEL2_M0: w_op2 = w_mux0;
      SEL2_R1: w_op2 = w_r1;
      SEL2_R2: w_op2 = w_r2;
      default: w_op2 = '0;
    endcase
  end

  // Both results are truncated to WIDTH: only the low half of the product is kept.
  assign w_sum  = w_op1 + w_op2;
  assign w_prod = w_op1 * w_op2;
  assign w_alu  = (H == OP_MUL) ? w_prod : w_sum;

  // Operands come from the registers' current outputs, so a register that is
  // both source and destination sees its pre-edge value.
  bo_reg #(.WIDTH(WIDTH)) u_r0 (.clk(clk), .rst(rst), .ld(LX), .d(x),     .q(w_r0));
  bo_reg #(.WIDTH(WIDTH)) u_r1 (.clk(clk), .rst(rst), .ld(LH), .d(w_alu), .q(w_r1));
  bo_reg #(.WIDTH(WIDTH)) u_r2 (.clk(clk), .rst(rst), .ld(LS), .d(w_alu), .q(w_r2));

  assign Pronto = w_r2;

endmodule

// File: tb/tb_bo_datapath.sv
// Directed bench for bo_datapath: reset priority, the 3x^2+2x+5 sequence,
// hold behaviour, 16-bit wrap-around, zero select and dual load.
module tb_bo_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A, B, C, x;
  logic [1:0]  M0, M1, M2;
  logic        LX, LH, LS, H;
  logic [15:0] Pronto;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bo_datapath #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .M0(M0), .x(x), .LX(LX),
    .M1(M1), .M2(M2), .LH(LH), .LS(LS), .H(H), .Pronto(Pronto)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; results sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic lx, input logic lh, input logic ls, input logic h,
                     input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2);
    LX = lx; LH = lh; LS = ls; H = h; M0 = m0; M1 = m1; M2 = m2;
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; C = '0; x = '0;
    ctl(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("init_pronto", Pronto, 16'd0);
    rst = 1'b0;

    // ---- Reset priority: preload R0=7, R1=9, R2=11
    x = 16'd7; ctl(1, 0, 0, 0, 0, 0, 0); tick();
    chk("pre_r0", dut.w_r0, 16'd7);
    B = 16'd2; ctl(0, 1, 0, 0, 2, 1, 1); tick();          // R1 = R0 + B
    chk("pre_r1", dut.w_r1, 16'd9);
    B = 16'd4; ctl(0, 0, 1, 0, 2, 1, 1); tick();          // R2 = R0 + B
    chk("pre_r2", Pronto, 16'd11);
    rst = 1'b1; ctl(1, 1, 1, 0, 2, 1, 1); tick();
    chk("rst_r0", dut.w_r0, 16'd0);
    chk("rst_r1", dut.w_r1, 16'd0);
    chk("rst_pronto", Pronto, 16'd0);
    rst = 1'b0; x = 16'd5; ctl(1, 0, 0, 0, 0, 0, 0); tick();
    chk("resume_r0", dut.w_r0, 16'd5);

    // ---- Polynomial 3x^2 + 2x + 5 at x=2
    A = 16'd3; B = 16'd2; C = 16'd5; x = 16'd2;
    ctl(1, 0, 0, 0, 0, 0, 0); tick();
    chk("poly_r0", dut.w_r0, 16'd2);
    ctl(0, 1, 0, 1, 0, 1, 0); tick();                     // R1 = x*x
    chk("poly_x2", dut.w_r1, 16'd4);
    ctl(0, 0, 1, 1, 1, 0, 2); tick();                     // R2 = A*R1
    chk("poly_ax2", Pronto, 16'd12);
    ctl(0, 1, 0, 1, 2, 0, 0); tick();                     // R1 = B*x
    chk("poly_bx", dut.w_r1, 16'd4);
    ctl(0, 0, 1, 0, 0, 2, 3); tick();                     // R2 = R1 + R2
    chk("poly_sum", Pronto, 16'd16);
    ctl(0, 0, 1, 0, 3, 0, 3); tick();                     // R2 = C + R2
    chk("poly_result", Pronto, 16'd21);

    // ---- Hold: enables low while everything else toggles
    for (int i = 0; i < 3; i++) begin
      A = 16'hA5A5 ^ 16'(i); B = 16'h1234 + 16'(i); C = 16'hFFFF; x = 16'(100 + i);
      ctl(0, 0, 0, i[0], 2'(i), 2'(i + 1), 2'(3 - i));
      tick();
    end
    chk("hold_r0", dut.w_r0, 16'd2);
    chk("hold_r1", dut.w_r1, 16'd4);
    chk("hold_pronto", Pronto, 16'd21);

    // ---- Wrap-around: 300*300 = 90000 -> 24464
    x = 16'd300; ctl(1, 0, 0, 0, 0, 0, 0); tick();
    ctl(0, 0, 1, 1, 0, 1, 0); tick();
    chk("wrap_mul", Pronto, 16'd24464);
    x = 16'hFFFF; ctl(1, 0, 0, 0, 0, 0, 0); tick();
    ctl(0, 1, 0, 0, 0, 0, 0); tick();                     // R1 = 0 + R0
    chk("wrap_r1", dut.w_r1, 16'hFFFF);
    x = 16'd1; ctl(1, 0, 0, 0, 0, 0, 0); tick();
    ctl(0, 0, 1, 0, 0, 0, 0); tick();                     // R2 = 0 + R0
    chk("wrap_r2", Pronto, 16'd1);
    ctl(0, 0, 1, 0, 0, 2, 3); tick();                     // R2 = R1 + R2 (reads old R2)
    chk("wrap_add", Pronto, 16'd0);

    // ---- Zero select and dual load
    A = 16'd77; B = 16'd88; C = 16'd99;
    x = 16'd5; ctl(1, 0, 0, 0, 0, 0, 0); tick();
    ctl(0, 1, 1, 0, 0, 0, 0); tick();                     // 0 + R0
    chk("dual_add_r1", dut.w_r1, 16'd5);
    chk("dual_add_r2", Pronto, 16'd5);
    ctl(0, 1, 1, 1, 0, 0, 0); tick();                     // 0 * R0
    chk("dual_mul_r1", dut.w_r1, 16'd0);
    chk("dual_mul_r2", Pronto, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bo_datapath.md
Name: bo_datapath

Overview:
- 16-bit operational datapath ("bloco operacional") that evaluates polynomials such as A·x² + B·x + C over a sequence of externally sequenced cycles.
- Contains:
  - 3 load-enabled registers: R0 holds x, R1 and R2 hold intermediates.
  - 3 four-input multiplexers: M0 selects the coefficient, M1 and M2 select the ALU operands.
  - 1 add/multiply ALU.
- All control is driven by an external control FSM; this block holds no state machine of its own.

Parameters:
- WIDTH, 16, data width of coefficients, registers, ALU and result.

Ports:
- clk  input  1  system clock; all registers update on the rising edge
- rst  input  1  synchronous, active-high reset; clears R0, R1, R2
- A  input  WIDTH  coefficient A
- B  input  WIDTH  coefficient B
- C  input  WIDTH  coefficient C
- M0  input  2  coefficient mux select: 0→constant 0, 1→A, 2→B, 3→C
- x  input  WIDTH  polynomial variable, captured into R0
- LX  input  1  load enable for R0
- M1  input  2  ALU operand-1 select: 0→M0 output, 1→R0, 2→R1, 3→R2
- M2  input  2  ALU operand-2 select: 0→R0, 1→M0 output, 2→R1, 3→R2
- LH  input  1  load enable for R1, loaded from the ALU result
- LS  input  1  load enable for R2, loaded from the ALU result
- H  input  1  ALU operation: 1→multiply, 0→add
- Pronto  output  WIDTH  result; continuously equals R2

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Clock and reset are fixed as stated.
- Reset: at a rising edge with rst=1, R0=R1=R2=0, so Pronto=0. Reset has priority over every load enable.
- Registers:
  - At a rising edge with rst=0: R0←x if LX; R1←alu if LH; R2←alu if LS.
  - A register whose enable is low holds its value.
  - LH and LS high together load the same ALU result into both R1 and R2.
  - A register may be both an ALU operand and the load target in the same cycle; it reads the pre-edge value.
- Multiplexers are purely combinational; they take no clock input.
  - mux0 = {0, A, B, C}[M0]
  - op1 = {mux0, R0, R1, R2}[M1]
  - op2 = {R0, mux0, R1, R2}[M2]
- ALU is purely combinational.
  - H=1: alu = (op1 × op2) mod 2^WIDTH, i.e. the low WIDTH bits of the product.
  - H=0: alu = (op1 + op2) mod 2^WIDTH.
  - Operands are unsigned. No carry, overflow or status outputs.
- Latency: one cycle. Select and enable inputs applied before edge k produce a register update visible after edge k. Pronto changes only after edges where LS=1 or rst=1.
- No X propagation from the constant-0 mux input. All select encodings are fully decoded; no illegal values exist.

Decomposition:
- Shared package bo_pkg holds:
  - WIDTH default
  - localparams for the select encodings: SEL0_ZERO/A/B/C, SEL1_M0/R0/R1/R2, SEL2_R0/M0/R1/R2
  - ALU opcodes OP_ADD=0, OP_MUL=1
- One natural sub-module, bo_reg: WIDTH-bit register with synchronous active-high reset and load enable. It is instantiated three times.
- Muxes and the ALU are inline combinational logic in the top.

Test Plan:
- Reset:
  - Preload R0=7, R1=9, R2=11, then rst=1 with LX=LH=LS=1 → all registers 0 after the edge, Pronto=0.
  - Deassert rst → loads resume on the next edge.
- Polynomial A=3, B=2, C=5, x=2, one step per clock edge; expected Pronto=21:
  - LX=1 → R0=2.
  - M1=1, M2=0, H=1, LH=1 → R1=4.
  - M0=1, M1=0, M2=2, H=1, LS=1 → R2=12.
  - M0=2, M1=0, M2=0, H=1, LH=1 → R1=4.
  - M1=2, M2=3, H=0, LS=1 → R2=16.
  - M0=3, M1=0, M2=3, H=0, LS=1 → R2=21, Pronto=21.
- Hold: all enables low for 3 cycles while A, B, C, x and selects toggle → R0, R1 and R2 unchanged.
- Wrap-around:
  - R0=300, M1=1, M2=0, H=1, LS=1 → Pronto=24464 (90000 mod 65536).
  - R1=0xFFFF, R2=1, H=0, M1=2, M2=3, LS=1 → Pronto=0.
- Zero select and dual load: M0=0, M1=0, M2=0, R0=5, H=0, LH=LS=1 → R1=R2=5. The same setup with H=1 → R1=R2=0.
